// File: rtl/board_row_fetcher_if.sv
// Row-fetch bundle: color-mapper request, board RAM read port and committed row.
// No backpressure: requests are edge-triggered, RAM answers one cycle after mem_rd.
interface board_row_fetcher_if #(
    parameter int BOARD_W = 10,
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8
);
    logic                            LD_Row;
    logic [7:0]                      rowNum;
    logic [ADDR_W-1:0]               mem_addr;
    logic                            mem_rd;
    logic [DATA_W-1:0]               mem_data;
    logic [BOARD_W-1:0][DATA_W-1:0]  Row;
    logic                            rowReady;
    logic                            busy;

    modport master (
        input  LD_Row, rowNum, mem_data,
        output mem_addr, mem_rd, Row, rowReady, busy
    );

    modport slave (
        output LD_Row, rowNum, mem_data,
        input  mem_addr, mem_rd, Row, rowReady, busy
    );
endinterface

// File: rtl/board_row_fetcher.sv
// Fetches one board row into a shadow buffer and commits it atomically to Row.
// Latency 12 cycles request-to-rowReady; requests while busy park in a one-deep, last-wins slot.
module board_row_fetcher #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20,
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8
) (
    input  logic                 Clk,
    input  logic                 reset,
    board_row_fetcher_if.master  bus
);
    localparam int               COL_W    = $clog2(BOARD_W);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(BOARD_W - 1);
    localparam logic [7:0]       ROW_LIM  = 8'(BOARD_H);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_COMMIT} state_t;

    state_t                         r_state, w_state_nxt;
    logic                           r_ld_prev, r_armed;
    logic                           r_pend_vld;
    logic [7:0]                     r_pend_row;
    logic                           r_mem_rd;
    logic [ADDR_W-1:0]              r_mem_addr;
    logic [COL_W-1:0]               r_col;
    logic                           r_vld;
    logic [COL_W-1:0]               r_vcol;
    logic [BOARD_W-1:0][DATA_W-1:0] r_shadow, w_shadow_nxt;
    logic [BOARD_W-1:0][DATA_W-1:0] r_row;
    logic                           r_row_ready;

    logic                           w_req;
    logic                           w_start;
    logic [7:0]                     w_start_row;
    logic                           w_start_in, w_clear;
    logic [ADDR_W-1:0]              w_base;

    // r_armed blocks an LD_Row that is already high when reset releases.
    assign w_req      = bus.LD_Row & ~r_ld_prev & r_armed;
    assign w_start_in = w_start & (w_start_row < ROW_LIM);
    assign w_clear    = w_start & ~(w_start_row < ROW_LIM);
    assign w_base     = ADDR_W'(w_start_row) * ADDR_W'(BOARD_W);

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_start_row = bus.rowNum;
        case (r_state)
            S_IDLE:   if (w_req) w_start = 1'b1;
            S_READ:   if (r_col == LAST_COL) w_state_nxt = S_DRAIN;
            S_DRAIN:  w_state_nxt = S_COMMIT;
            S_COMMIT: begin
                w_state_nxt = S_IDLE;
                if (w_req) begin
                    w_start = 1'b1;
                end else if (r_pend_vld) begin
                    w_start     = 1'b1;
                    w_start_row = r_pend_row;
                end
            end
            default:  w_state_nxt = S_IDLE;
        endcase
        if (w_start) w_state_nxt = w_start_in ? S_READ : S_COMMIT;
    end

    // Commit uses the next-shadow value so the word captured in DRAIN lands in Row.
    always_comb begin
        w_shadow_nxt = r_shadow;
        if (w_clear)
            w_shadow_nxt = '0;
        else if (r_vld)
            w_shadow_nxt[r_vcol] = bus.mem_data;
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_ld_prev   <= 1'b0;
            r_armed     <= 1'b0;
            r_pend_vld  <= 1'b0;
            r_pend_row  <= '0;
            r_mem_rd    <= 1'b0;
            r_mem_addr  <= '0;
            r_col       <= '0;
            r_vld       <= 1'b0;
            r_vcol      <= '0;
            r_shadow    <= '0;
            r_row       <= '0;
            r_row_ready <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ld_prev <= bus.LD_Row;
            if (!bus.LD_Row) r_armed <= 1'b1;

            if (r_state == S_COMMIT) begin
                r_pend_vld <= 1'b0;
            end else if (w_req && r_state != S_IDLE) begin
                r_pend_vld <= 1'b1;
                r_pend_row <= bus.rowNum;
            end

            if (w_start_in) begin
                r_mem_rd   <= 1'b1;
                r_mem_addr <= w_base;
                r_col      <= '0;
            end else if (r_state == S_READ) begin
                if (r_col == LAST_COL) begin
                    r_mem_rd <= 1'b0;
                end else begin
                    r_col      <= r_col + 1'b1;
                    r_mem_addr <= r_mem_addr + 1'b1;
                end
            end

            r_vld    <= r_mem_rd;
            r_vcol   <= r_col;
            r_shadow <= w_shadow_nxt;

            r_row_ready <= (w_state_nxt == S_COMMIT);
            if (w_state_nxt == S_COMMIT) r_row <= w_shadow_nxt;
        end
    end

    assign bus.mem_addr = r_mem_addr;
    assign bus.mem_rd   = r_mem_rd;
    assign bus.Row      = r_row;
    assign bus.rowReady = r_row_ready;
    assign bus.busy     = (r_state != S_IDLE);
endmodule

// File: tb/tb_board_row_fetcher.sv
// Directed bench for board_row_fetcher against a RAM holding {8'h00, addr} per cell.
module tb_board_row_fetcher;
    logic Clk;
    logic reset;
    int   cyc = 0;
    int   t0;
    int   n_pass = 0;
    int   n_total = 0;
    int   n_fail = 0;

    int          rd_cyc[$];
    logic [7:0]  rd_addr[$];
    int          rdy_cyc[$];
    logic [15:0] rdy_row0[$];
    int          bsy_cyc[$];

    board_row_fetcher_if #(.BOARD_W(10), .DATA_W(16), .ADDR_W(8)) bus ();

    board_row_fetcher #(.BOARD_W(10), .BOARD_H(20), .DATA_W(16), .ADDR_W(8)) dut (
        .Clk   (Clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    always @(posedge Clk) begin
        if (bus.mem_rd) bus.mem_data <= {8'h00, bus.mem_addr};
    end

    always @(negedge Clk) begin
        if (bus.mem_rd) begin
            rd_cyc.push_back(cyc);
            rd_addr.push_back(bus.mem_addr);
        end
        if (bus.rowReady) begin
            rdy_cyc.push_back(cyc);
            rdy_row0.push_back(bus.Row[0]);
        end
        if (bus.busy) bsy_cyc.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic clr_q();
        rd_cyc.delete();
        rd_addr.delete();
        rdy_cyc.delete();
        rdy_row0.delete();
        bsy_cyc.delete();
    endtask

    task automatic pulse(input logic [7:0] r);
        bus.rowNum = r;
        bus.LD_Row = 1'b1;
        tick(1);
        bus.LD_Row = 1'b0;
    endtask

    initial begin
        int hits;
        reset        = 1'b0;
        bus.LD_Row   = 1'b0;
        bus.rowNum   = 8'd0;
        bus.mem_data = 16'h0000;
        tick(3);
        chk("rst_row", {31'b0, |bus.Row}, 32'd0);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_rd", {31'b0, bus.mem_rd}, 32'd0);
        chk("rst_addr", {24'b0, bus.mem_addr}, 32'd0);
        chk("rst_rdy", {31'b0, bus.rowReady}, 32'd0);
        reset = 1'b1;
        tick(2);

        // Row 3: addresses 30..39 in cycles 1..10, commit in cycle 12.
        clr_q();
        t0 = cyc;
        pulse(8'd3);
        tick(15);
        chk("r3_rd_cnt", rd_cyc.size(), 32'd10);
        chk("r3_rd_first", rd_cyc[0] - t0, 32'd1);
        chk("r3_rd_last", rd_cyc[9] - t0, 32'd10);
        for (int k = 0; k < 10; k++) chk($sformatf("r3_addr%0d", k), {24'b0, rd_addr[k]}, 32'd30 + k);
        chk("r3_rdy_cnt", rdy_cyc.size(), 32'd1);
        chk("r3_rdy_cyc", rdy_cyc[0] - t0, 32'd12);
        chk("r3_busy_cnt", bsy_cyc.size(), 32'd12);
        chk("r3_busy_first", bsy_cyc[0] - t0, 32'd1);
        for (int k = 0; k < 10; k++) chk($sformatf("r3_row%0d", k), {16'b0, bus.Row[k]}, 32'h1E + k);

        // Held LD_Row is one request.
        clr_q();
        bus.rowNum = 8'd5;
        bus.LD_Row = 1'b1;
        tick(40);
        bus.LD_Row = 1'b0;
        tick(5);
        chk("hold_rd_cnt", rd_cyc.size(), 32'd10);
        chk("hold_rdy_cnt", rdy_cyc.size(), 32'd1);
        chk("hold_row0", {16'b0, bus.Row[0]}, 32'd50);
        chk("hold_row9", {16'b0, bus.Row[9]}, 32'd59);

        // Out-of-range rows 20 and 255.
        clr_q();
        t0 = cyc;
        pulse(8'd20);
        tick(4);
        chk("oor20_rd_cnt", rd_cyc.size(), 32'd0);
        chk("oor20_rdy_cnt", rdy_cyc.size(), 32'd1);
        chk("oor20_rdy_cyc", rdy_cyc[0] - t0, 32'd1);
        chk("oor20_row", {31'b0, |bus.Row}, 32'd0);
        pulse(8'd3);
        tick(15);
        clr_q();
        t0 = cyc;
        pulse(8'd255);
        tick(4);
        chk("oor255_rd_cnt", rd_cyc.size(), 32'd0);
        chk("oor255_rdy_cyc", rdy_cyc[0] - t0, 32'd1);
        chk("oor255_row", {31'b0, |bus.Row}, 32'd0);

        // Row 2, then 7 and 9 while busy: 9 overwrites 7 in the pending slot.
        clr_q();
        t0 = cyc;
        pulse(8'd2);
        tick(2);
        pulse(8'd7);
        tick(1);
        pulse(8'd9);
        tick(30);
        chk("b2b_rd_cnt", rd_cyc.size(), 32'd20);
        chk("b2b_addr0", {24'b0, rd_addr[0]}, 32'd20);
        chk("b2b_addr10", {24'b0, rd_addr[10]}, 32'd90);
        chk("b2b_addr19", {24'b0, rd_addr[19]}, 32'd99);
        chk("b2b_rd2_cyc", rd_cyc[10] - t0, 32'd13);
        chk("b2b_rdy_cnt", rdy_cyc.size(), 32'd2);
        chk("b2b_rdy0_cyc", rdy_cyc[0] - t0, 32'd12);
        chk("b2b_rdy0_row", {16'b0, rdy_row0[0]}, 32'd20);
        chk("b2b_rdy1_cyc", rdy_cyc[1] - t0, 32'd24);
        hits = 0;
        foreach (rd_addr[i]) if (rd_addr[i] >= 8'd70 && rd_addr[i] <= 8'd79) hits++;
        chk("b2b_row7_reads", hits, 32'd0);
        chk("b2b_row9", {16'b0, bus.Row[9]}, 32'd99);

        // Reset in cycle 6 of a fetch, with LD_Row left high across release.
        clr_q();
        t0 = cyc;
        pulse(8'd4);
        tick(5);
        chk("mid_rd", {31'b0, bus.mem_rd}, 32'd1);
        reset = 1'b0;
        #1;
        chk("arst_row", {31'b0, |bus.Row}, 32'd0);
        chk("arst_busy", {31'b0, bus.busy}, 32'd0);
        chk("arst_rd", {31'b0, bus.mem_rd}, 32'd0);
        chk("arst_addr", {24'b0, bus.mem_addr}, 32'd0);
        bus.rowNum = 8'd1;
        bus.LD_Row = 1'b1;
        tick(3);
        clr_q();
        reset = 1'b1;
        tick(15);
        chk("arst_held_rd", rd_cyc.size(), 32'd0);
        chk("arst_held_rdy", rdy_cyc.size(), 32'd0);
        bus.LD_Row = 1'b0;
        tick(1);
        clr_q();
        t0 = cyc;
        pulse(8'd1);
        tick(15);
        chk("post_rd_first", rd_cyc[0] - t0, 32'd1);
        chk("post_addr0", {24'b0, rd_addr[0]}, 32'd10);
        chk("post_rdy_cyc", rdy_cyc[0] - t0, 32'd12);
        chk("post_row0", {16'b0, bus.Row[0]}, 32'd10);

        // Last row: addresses 190..199 without wrap.
        clr_q();
        t0 = cyc;
        pulse(8'd19);
        tick(15);
        chk("r19_addr0", {24'b0, rd_addr[0]}, 32'd190);
        chk("r19_addr9", {24'b0, rd_addr[9]}, 32'd199);
        chk("r19_row0", {16'b0, bus.Row[0]}, 32'd190);
        chk("r19_row9", {16'b0, bus.Row[9]}, 32'd199);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
